imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time program loader for the single-cycle CPU's instruction memory.
//  - Accepts a byte stream over a valid/ready handshake.
//  - Assembles the bytes little-endian into 32-bit instruction words.
//  - Writes those words to instruction memory starting at word 0.
//  - Holds the CPU in reset until the load completes, then releases it.
//  Sits between the host/testbench byte source and the top-level CPU's imem write port and reset input.
// PARAMETERS
//  ADDR_W  6   imem word-address width (64 words, matches the 8-bit byte PC)
//  DATA_W  32  instruction word width; fixed at 4 bytes
// PORTS
//  clk          in   1         system clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  start        in   1         1-cycle pulse: begin a load; sampled only in IDLE
//  num_words    in   ADDR_W+1  words to load; 0 = no load; values >2**ADDR_W are clamped to 2**ADDR_W
//  in_valid     in   1         byte-source data valid
//  in_data      in   8         byte-source data
//  in_ready     out  1         loader can accept a byte
//  imem_we      out  1         instruction-memory write strobe, 1 cycle per word
//  imem_addr    out  ADDR_W    instruction-memory word address
//  imem_wdata   out  DATA_W    assembled instruction word
//  cpu_rst_n    out  1         active-low reset to CPU core
//  busy         out  1         load in progress
//  done         out  1         sticky: last load finished; cleared when the next start is accepted
// BEHAVIOUR
//  Reset values (async): FSM=IDLE; all outputs 0.
//   - cpu_rst_n=0: the CPU is held in reset after power-up until a load, possibly empty, completes.
//   - Internal byte_idx=0, word_cnt=0, and the assembly register=0.
//  FSM states: IDLE, RECV, WRITE, FINISH.
//  IDLE:
//   - start=1 and num_words=0 -> FINISH.
//   - start=1 and num_words!=0:
//       - Latch the clamped num_words.
//       - word_cnt<=0, byte_idx<=0, done<=0, cpu_rst_n<=0, busy<=1.
//       - Go to RECV.
//   - start is ignored in every state other than IDLE.
//  RECV:
//   - in_ready=1.
//   - A byte transfers on in_valid&&in_ready; bit bi of in_data goes to word bit 8*byte_idx+bi (byte 0 -> [7:0]).
//   - Each transfer increments byte_idx mod 4.
//   - The transfer with byte_idx==3 moves the FSM to WRITE.
//   - in_valid=0 stalls indefinitely with no state change.
//  WRITE, exactly 1 cycle:
//   - in_ready=0, imem_we=1, imem_addr=word_cnt, imem_wdata=assembled word.
//   - If word_cnt==num_words-1 -> FINISH; else word_cnt++ and return to RECV.
//  FINISH, 1 cycle:
//   - busy<=0, done<=1, cpu_rst_n<=1 (registered); next state IDLE.
//  Timing and throughput:
//   - imem_we is asserted in the cycle after the 4th byte's handshake.
//   - Maximum throughput is 4 bytes per 5 cycles.
//   - cpu_rst_n rises 1 cycle after the last imem_we.
//  Other output rules:
//   - imem_addr/imem_wdata hold their last values when imem_we=0.
//   - in_ready is 0 in IDLE, WRITE and FINISH.
//  Reload: start in IDLE after done re-asserts cpu_rst_n=0 the cycle after start is accepted.
//  Reset mid-load:
//   - All state returns to reset values; a partial word is discarded and no imem_we is issued.
//   - The CPU stays in reset.
//  Word-address wrap: impossible, because num_words is clamped; word_cnt never exceeds 2**ADDR_W-1.
// TESTING
//  T1:
//   - Stimulus: reset, start with num_words=1, bytes 0x13,0x00,0x01,0x20 with no stalls.
//   - Response: one imem_we with addr=0, wdata=0x20010013; cpu_rst_n=1 and done=1 the next cycle.
//  T2:
//   - Stimulus: num_words=3, 12 bytes 0x00..0x0B, with in_valid dropped for 3 cycles mid-word 2.
//   - Response: writes addr0=0x03020100, addr1=0x07060504, addr2=0x0B0A0908; no extra writes.
//  T3:
//   - Stimulus: start with num_words=0.
//   - Response: no imem_we; in_ready never 1; done=1 and cpu_rst_n=1 two cycles after start.
//  T4:
//   - Stimulus: num_words=100.
//   - Response: exactly 64 writes at addr 0..63; then done.
//  T5:
//   - Stimulus: rst_n low after 6 bytes of a 2-word load, then a fresh start with num_words=1 and bytes AA,BB,CC,DD.
//   - Response: only the word 0 write (from the first load) precedes the reset; the reload writes addr=0, wdata=0xDDCCBBAA.
//   - Response: cpu_rst_n=0 throughout until the final FINISH.
//  T6:
//   - Stimulus: start pulsed while busy; then a second start after done.
//   - Response: the first pulse is ignored; the second start drops cpu_rst_n to 0 and clears done the next cycle.

Source files
------------

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Byte-stream valid/ready handshake that feeds the instruction-memory loader.
//
//   Signals
//     in_valid  source -> loader   byte on in_data is valid
//     in_data   source -> loader   8-bit payload
//     in_ready  loader -> source   loader accepts a byte this cycle
//
//   Modports
//     master    byte source (host / testbench)
//     slave     loader
// -----------------------------------------------------------------------------
interface imem_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input  in_ready);
   modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface : imem_loader_if

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time program loader for the single-cycle CPU's instruction memory.
//   Bytes arrive over a valid/ready stream, are packed little-endian into
//   32-bit words, and are written to instruction memory from word 0 upward.
//   The CPU is held in reset until a load (possibly empty) completes.
//
//   Ports
//     clk         in   system clock, rising edge
//     rst_n       in   asynchronous active-low reset
//     start       in   1-cycle pulse, begins a load; only honoured in IDLE
//     num_words   in   words to load (0 = empty load, >2**ADDR_W clamped)
//     stream      if   byte-stream slave (in_valid / in_data / in_ready)
//     imem_we     out  instruction-memory write strobe, one cycle per word
//     imem_addr   out  instruction-memory word address
//     imem_wdata  out  assembled instruction word
//     cpu_rst_n   out  active-low reset to the CPU core
//     busy        out  load in progress
//     done        out  sticky: last load finished; cleared by next start
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   imem_loader_if.slave      stream,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done
);

   // Largest legal load: the whole memory.
   localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W + 1)'(1) << ADDR_W;
   localparam logic [ADDR_W:0] ONE_WORD  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      WRITE  = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [1:0]        byte_idx;     // next byte lane to fill
   logic [ADDR_W-1:0] word_cnt;     // address of the word being assembled
   logic [ADDR_W:0]   num_lat;      // clamped word count for this load
   logic [23:0]       asm_lo;       // lower three bytes of the word in flight

   logic              xfer;
   logic              last_word;
   logic [ADDR_W:0]   num_clamped;

   assign xfer        = stream.in_valid && stream.in_ready;
   assign last_word   = ({1'b0, word_cnt} == (num_lat - ONE_WORD));
   assign num_clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of its inputs, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and Moore outputs
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt       = state;
      stream.in_ready = 1'b0;
      imem_we         = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (num_words == '0) ? FINISH : RECV;
            end
         end

         RECV: begin
            stream.in_ready = 1'b1;
            if (xfer && (byte_idx == 2'd3)) begin
               state_nxt = WRITE;
            end
         end

         WRITE: begin
            imem_we   = 1'b1;
            state_nxt = last_word ? FINISH : RECV;
         end

         FINISH: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath and registered status outputs
   // ---------------------------------------------------------------------------
   // imem_addr / imem_wdata are loaded when the fourth byte lands, so they are
   // already valid for the WRITE cycle and then hold until the next word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx   <= 2'd0;
         word_cnt   <= '0;
         num_lat    <= '0;
         asm_lo     <= '0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_rst_n  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // An accepted start, even an empty one, clears the sticky
                  // done and puts the CPU back into reset until FINISH.
                  done      <= 1'b0;
                  cpu_rst_n <= 1'b0;
                  if (num_words != '0) begin
                     num_lat  <= num_clamped;
                     word_cnt <= '0;
                     byte_idx <= 2'd0;
                     busy     <= 1'b1;
                  end
               end
            end

            RECV: begin
               if (xfer) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: asm_lo[7:0]   <= stream.in_data;
                     2'd1: asm_lo[15:8]  <= stream.in_data;
                     2'd2: asm_lo[23:16] <= stream.in_data;
                     default: begin
                        // Top byte goes straight into the write register.
                        imem_wdata <= {stream.in_data, asm_lo};
                        imem_addr  <= word_cnt;
                     end
                  endcase
               end
            end

            WRITE: begin
               if (!last_word) begin
                  word_cnt <= word_cnt + ADDR_W'(1);
               end
            end

            FINISH: begin
               busy      <= 1'b0;
               done      <= 1'b1;
               cpu_rst_n <= 1'b1;
            end

            default: begin
            end
         endcase
      end
   end

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. Expected writes are queued when the
//   bytes are driven and popped by a write monitor when imem_we fires.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W:0]   num_words = '0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_wdata;
   logic              cpu_rst_n;
   logic              busy;
   logic              done;

   imem_loader_if stream ();

   always #5 clk = ~clk;

   imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_words  (num_words),
      .stream     (stream),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   typedef struct {
      int         req;         // num_words driven
      int         stall_word;  // word index with a stall before its byte 2 (-1 none)
      int         stall_cyc;   // idle cycles of the stall
      logic [7:0] base;        // first byte value; bytes count up from here
      int         exp_words;   // writes the loader must issue
   } vec_t;

   wr_t  exp_q[$];
   vec_t vecs[6];
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   wr_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Write monitor / scoreboard consumer.
   always @(negedge clk) begin
      if (rst_n && imem_we) begin
         wr_t e;
         wr_cnt++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                     imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(imem_addr), 32'(e.addr));
            check("wr_data", imem_wdata, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input int addr, input logic [31:0] data);
      wr_t e;
      e.addr = ADDR_W'(addr);
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic do_start(input int n);
      start     = 1'b1;
      num_words = (ADDR_W + 1)'(n);
      tick();
      start     = 1'b0;
      num_words = '0;
   endtask

   // Present one byte and return just after the edge it transferred on.
   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      stream.in_valid = 1'b1;
      stream.in_data  = b;
      while (!stream.in_ready && guard < 200) begin
         tick();
         guard++;
      end
      if (!stream.in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: got in_ready=0 for %0d cycles, expected 1", guard);
      end
      tick();
   endtask

   task automatic wait_done();
      int cycles = 0;
      while (!done && cycles < 1000) begin
         tick();
         cycles++;
      end
      check("done_reached", 32'(done), 32'd1);
   endtask

   task automatic run_load(input vec_t v, input int idx);
      logic [7:0]  b;
      logic [31:0] w_data;
      logic [31:0] last_data;
      last_data = '0;
      wr_cnt    = 0;
      for (int w = 0; w < v.exp_words; w++) begin
         for (int j = 0; j < 4; j++) begin
            b = v.base + 8'(4 * w + j);
            w_data[8*j +: 8] = b;
         end
         push_word(w, w_data);
         last_data = w_data;
      end
      do_start(v.req);
      check($sformatf("v%0d_busy_on_start", idx), 32'(busy), 32'd1);
      check($sformatf("v%0d_cpu_rst_on_start", idx), 32'(cpu_rst_n), 32'd0);
      check($sformatf("v%0d_done_cleared", idx), 32'(done), 32'd0);
      for (int w = 0; w < v.exp_words; w++) begin
         for (int j = 0; j < 4; j++) begin
            if (w == v.stall_word && j == 2) begin
               stream.in_valid = 1'b0;
               repeat (v.stall_cyc) tick();
            end
            send_byte(v.base + 8'(4 * w + j));
         end
      end
      stream.in_valid = 1'b0;
      wait_done();
      check($sformatf("v%0d_write_count", idx), 32'(wr_cnt), 32'(v.exp_words));
      check($sformatf("v%0d_queue_empty", idx), 32'(exp_q.size()), 32'd0);
      check($sformatf("v%0d_cpu_released", idx), 32'(cpu_rst_n), 32'd1);
      check($sformatf("v%0d_busy_clear", idx), 32'(busy), 32'd0);
      check($sformatf("v%0d_addr_hold", idx), 32'(imem_addr), 32'(v.exp_words - 1));
      check($sformatf("v%0d_wdata_hold", idx), imem_wdata, last_data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200us, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      stream.in_valid = 1'b0;
      stream.in_data  = 8'h00;

      vecs[0] = '{req: 3,   stall_word: 1,  stall_cyc: 3, base: 8'h00, exp_words: 3};
      vecs[1] = '{req: 100, stall_word: -1, stall_cyc: 0, base: 8'h40, exp_words: 64};
      vecs[2] = '{req: 64,  stall_word: -1, stall_cyc: 0, base: 8'hC0, exp_words: 64};
      vecs[3] = '{req: 65,  stall_word: 10, stall_cyc: 2, base: 8'h10, exp_words: 64};
      vecs[4] = '{req: 2,   stall_word: 0,  stall_cyc: 5, base: 8'h80, exp_words: 2};
      vecs[5] = '{req: 5,   stall_word: 4,  stall_cyc: 1, base: 8'h33, exp_words: 5};

      // ---------------- reset state ----------------
      #2 rst_n = 1'b0;
      #20;
      check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_imem_we", 32'(imem_we), 32'd0);
      check("rst_in_ready", 32'(stream.in_ready), 32'd0);
      check("rst_imem_addr", 32'(imem_addr), 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      check("idle_in_ready", 32'(stream.in_ready), 32'd0);

      // ---------------- T1: single word, write latency ----------------
      wr_cnt = 0;
      push_word(0, 32'h2001_0013);
      do_start(1);
      send_byte(8'h13);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h20);
      stream.in_valid = 1'b0;
      check("t1_we_after_4th", 32'(imem_we), 32'd1);
      check("t1_ready_in_write", 32'(stream.in_ready), 32'd0);
      tick();
      check("t1_single_we", 32'(imem_we), 32'd0);
      tick();
      check("t1_done", 32'(done), 32'd1);
      check("t1_cpu_released", 32'(cpu_rst_n), 32'd1);
      check("t1_write_count", 32'(wr_cnt), 32'd1);

      // ---------------- table-driven loads (T2, T4, clamp edges) ----------------
      for (int i = 0; i < 6; i++) begin
         run_load(vecs[i], i);
         tick();
      end

      // ---------------- T3: empty load ----------------
      wr_cnt = 0;
      do_start(0);
      check("t3_done_cleared", 32'(done), 32'd0);
      check("t3_ready_c1", 32'(stream.in_ready), 32'd0);
      check("t3_busy_c1", 32'(busy), 32'd0);
      tick();
      check("t3_done", 32'(done), 32'd1);
      check("t3_cpu_released", 32'(cpu_rst_n), 32'd1);
      check("t3_ready_c2", 32'(stream.in_ready), 32'd0);
      check("t3_no_write", 32'(wr_cnt), 32'd0);

      // ---------------- T5: reset mid-load, then reload ----------------
      wr_cnt = 0;
      push_word(0, 32'h5352_5150);
      do_start(2);
      for (int j = 0; j < 6; j++) send_byte(8'h50 + 8'(j));
      stream.in_valid = 1'b0;
      check("t5_cpu_held_mid", 32'(cpu_rst_n), 32'd0);
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_cpu", 32'(cpu_rst_n), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_done", 32'(done), 32'd0);
      check("t5_rst_ready", 32'(stream.in_ready), 32'd0);
      check("t5_rst_wdata", imem_wdata, 32'd0);
      check("t5_pre_writes", 32'(wr_cnt), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      tick();
      tick();
      check("t5_no_stray_write", 32'(wr_cnt), 32'd1);
      check("t5_cpu_still_held", 32'(cpu_rst_n), 32'd0);
      push_word(0, 32'hDDCC_BBAA);
      do_start(1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      check("t5_cpu_held_reload", 32'(cpu_rst_n), 32'd0);
      send_byte(8'hDD);
      stream.in_valid = 1'b0;
      check("t5_cpu_held_write", 32'(cpu_rst_n), 32'd0);
      wait_done();
      check("t5_reload_writes", 32'(wr_cnt), 32'd2);
      check("t5_cpu_released", 32'(cpu_rst_n), 32'd1);
      check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

      // ---------------- T6: start while busy, then reload after done ----------------
      wr_cnt = 0;
      push_word(0, 32'h6362_6160);
      push_word(1, 32'h6766_6564);
      do_start(2);
      send_byte(8'h60);
      stream.in_valid = 1'b0;
      start     = 1'b1;
      num_words = (ADDR_W + 1)'(1);
      tick();
      start     = 1'b0;
      num_words = '0;
      check("t6_busy_ignores_start", 32'(busy), 32'd1);
      for (int j = 1; j < 8; j++) send_byte(8'h60 + 8'(j));
      stream.in_valid = 1'b0;
      wait_done();
      check("t6_write_count", 32'(wr_cnt), 32'd2);
      check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
      tick();
      check("t6_done_sticky", 32'(done), 32'd1);
      push_word(0, 32'h7372_7170);
      do_start(1);
      check("t6_reload_cpu_rst", 32'(cpu_rst_n), 32'd0);
      check("t6_reload_done_clr", 32'(done), 32'd0);
      for (int j = 0; j < 4; j++) send_byte(8'h70 + 8'(j));
      stream.in_valid = 1'b0;
      wait_done();
      check("t6_reload_writes", 32'(wr_cnt), 32'd3);
      check("t6_final_queue", 32'(exp_q.size()), 32'd0);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_imem_loader
